// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load width codes and CSR addresses.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [11:0] CSR_ADDR_TOHOST  = 12'h51E;
  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;

endpackage

// File: rtl/wb_load_extend.sv
// Load data alignment and sign/zero extension. Misaligned addresses never
// trap: halfwords use addr[1] only, words ignore the address entirely.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] i_dmem_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0: w_byte = i_dmem_rdata[7:0];
      2'd1: w_byte = i_dmem_rdata[15:8];
      2'd2: w_byte = i_dmem_rdata[23:16];
      2'd3: w_byte = i_dmem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = i_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    o_result = 32'h0;
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'h0, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'h0, w_half};
      F3_LW:   o_result = i_dmem_rdata;
      default: o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Stage-3 pipeline register and writeback mux with tohost CSR capture.
// Define WB_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [11:0] CSR_TOHOST_ADDR = CSR_ADDR_TOHOST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        s2_valid,
  input  logic [4:0]  s2_rd,
  input  logic        s2_we,
  input  logic [1:0]  s2_wb_sel,
  input  logic [2:0]  s2_funct3,
  input  logic [31:0] s2_alu_result,
  input  logic [31:0] s2_pc_plus4,
  input  logic        s2_csr_we,
  input  logic [11:0] s2_csr_addr,
  input  logic [31:0] s2_csr_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] wb_data,
  output logic        we,
  output logic [31:0] csr_tohost
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  logic        r_valid;
  logic [4:0]  r_rd;
  logic        r_we;
  wb_sel_e     r_wb_sel;
  logic [2:0]  r_funct3;
  logic [31:0] r_alu_result;
  logic [31:0] r_pc_plus4;
  logic        r_csr_we;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_wdata;
  logic [31:0] r_csr_tohost;
  logic [31:0] w_load_data;
  logic        w_tohost_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rd         <= 5'd0;
      r_we         <= 1'b0;
      r_wb_sel     <= WB_ALU;
      r_funct3     <= 3'd0;
      r_alu_result <= 32'h0;
      r_pc_plus4   <= 32'h0;
      r_csr_we     <= 1'b0;
      r_csr_addr   <= 12'h0;
      r_csr_wdata  <= 32'h0;
    end else if (!stall) begin
      r_valid      <= s2_valid;
      r_rd         <= s2_rd;
      r_we         <= s2_we;
      r_wb_sel     <= wb_sel_e'(s2_wb_sel);
      r_funct3     <= s2_funct3;
      r_alu_result <= s2_alu_result;
      r_pc_plus4   <= s2_pc_plus4;
      r_csr_we     <= s2_csr_we;
      r_csr_addr   <= s2_csr_addr;
      r_csr_wdata  <= s2_csr_wdata;
    end
  end

  // The CSR write retires at the same edge the register file commits.
  assign w_tohost_wr = r_valid & r_csr_we & (r_csr_addr == CSR_TOHOST_ADDR) & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csr_tohost <= 32'h0;
    end else if (w_tohost_wr) begin
      r_csr_tohost <= r_csr_wdata;
    end
  end

  load_extend u_load_extend (
    .i_dmem_rdata (dmem_rdata),
    .i_funct3     (r_funct3),
    .i_addr       (r_alu_result[1:0]),
    .o_result     (w_load_data)
  );

  always_comb begin
    wb_data = 32'h0;
    case (r_wb_sel)
      WB_ALU:  wb_data = r_alu_result;
      WB_MEM:  wb_data = w_load_data;
      WB_PC4:  wb_data = r_pc_plus4;
      WB_CSR:  wb_data = r_csr_tohost;
      default: wb_data = 32'h0;
    endcase
  end

  assign rd         = r_rd;
  assign we         = r_valid & r_we & (r_rd != 5'd0) & ~stall;
  assign csr_tohost = r_csr_tohost;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= 32'h0;
      r_instret_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_valid && !stall) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
